clint_arbiter: RTL and testbench

CLINT_ARBITER -- requirements
Module: clint_arbiter

---
 rtl/clint_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_clint_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_arbiter.sv
// Round-robin arbiter funnelling N single-beat masters onto one CLINT slave port.
// One access in flight at a time; a WAIT watchdog aborts accesses the slave never answers.
module clint_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_MASTERS-1:0]             m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]      m_address,
    input  logic [N_MASTERS*DATA_W-1:0]      m_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]  m_wstrb,
    output logic [DATA_W-1:0]                m_rdata,
    output logic [N_MASTERS-1:0]             m_ready,
    output logic [N_MASTERS-1:0]             m_err,
    output logic                             s_valid,
    output logic [ADDR_W-1:0]                s_address,
    output logic [DATA_W-1:0]                s_wdata,
    output logic [(DATA_W/8)-1:0]            s_wstrb,
    input  logic [DATA_W-1:0]                s_rdata,
    input  logic                             s_ready,
    output logic                             busy
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned GNT_W  = $clog2(N_MASTERS);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_MASTERS-1:0] r_pending;
    logic [N_MASTERS-1:0] w_pending_nxt;
    logic [N_MASTERS-1:0] w_accept;
    logic [GNT_W-1:0]     r_grant;
    logic [GNT_W-1:0]     w_grant_nxt;
    logic [GNT_W-1:0]     r_last;
    logic [GNT_W-1:0]     w_last_nxt;
    logic [GNT_W-1:0]     w_pick;
    logic [GNT_W-1:0]     w_idx;
    logic                 w_found;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic [ADDR_W-1:0]    r_req_addr  [N_MASTERS];
    logic [DATA_W-1:0]    r_req_wdata [N_MASTERS];
    logic [STRB_W-1:0]    r_req_wstrb [N_MASTERS];

    logic                 r_s_valid,   w_s_valid_nxt;
    logic [ADDR_W-1:0]    r_s_address, w_s_address_nxt;
    logic [DATA_W-1:0]    r_s_wdata,   w_s_wdata_nxt;
    logic [STRB_W-1:0]    r_s_wstrb,   w_s_wstrb_nxt;
    logic [DATA_W-1:0]    r_m_rdata,   w_m_rdata_nxt;
    logic [N_MASTERS-1:0] r_m_ready,   w_m_ready_nxt;
    logic [N_MASTERS-1:0] r_m_err,     w_m_err_nxt;
    logic                 r_busy,      w_busy_nxt;

    // A master may queue one request, and only when it has nothing pending or in flight.
    always_comb begin
        w_accept = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            w_accept[i] = m_valid[i] & ~r_pending[i]
                        & ~((r_state != ST_IDLE) && (r_grant == GNT_W'(i)));
        end
    end

    // Round-robin pick: first pending master after the last one served.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            w_idx = GNT_W'((32'(r_last) + 32'(k)) % 32'(N_MASTERS));
            if (!w_found && r_pending[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending | w_accept;
        w_grant_nxt     = r_grant;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        w_s_valid_nxt   = 1'b0;
        w_s_address_nxt = r_s_address;
        w_s_wdata_nxt   = r_s_wdata;
        w_s_wstrb_nxt   = r_s_wstrb;
        w_m_rdata_nxt   = r_m_rdata;
        w_m_ready_nxt   = '0;
        w_m_err_nxt     = '0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_grant_nxt             = w_pick;
                    w_pending_nxt[w_pick]   = 1'b0;
                    w_s_valid_nxt           = 1'b1;
                    w_s_address_nxt         = r_req_addr[w_pick];
                    w_s_wdata_nxt           = r_req_wdata[w_pick];
                    w_s_wstrb_nxt           = r_req_wstrb[w_pick];
                    w_state_nxt             = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (s_ready) begin
                    w_m_rdata_nxt          = s_rdata;
                    w_m_ready_nxt[r_grant] = 1'b1;
                    w_last_nxt             = r_grant;
                    w_state_nxt            = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    // Counter reaches TIMEOUT on this edge: abort with an error pulse.
                    w_cnt_nxt              = CNT_W'(TIMEOUT);
                    w_m_rdata_nxt          = '0;
                    w_m_ready_nxt[r_grant] = 1'b1;
                    w_m_err_nxt[r_grant]   = 1'b1;
                    w_last_nxt             = r_grant;
                    w_state_nxt            = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_grant     <= '0;
            r_last      <= GNT_W'(N_MASTERS - 1);
            r_cnt       <= '0;
            r_s_valid   <= 1'b0;
            r_s_address <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_m_rdata   <= '0;
            r_m_ready   <= '0;
            r_m_err     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_s_valid   <= w_s_valid_nxt;
            r_s_address <= w_s_address_nxt;
            r_s_wdata   <= w_s_wdata_nxt;
            r_s_wstrb   <= w_s_wstrb_nxt;
            r_m_rdata   <= w_m_rdata_nxt;
            r_m_ready   <= w_m_ready_nxt;
            r_m_err     <= w_m_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Per-master request capture on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                r_req_addr[i]  <= '0;
                r_req_wdata[i] <= '0;
                r_req_wstrb[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (w_accept[i]) begin
                    r_req_addr[i]  <= m_address[i*ADDR_W +: ADDR_W];
                    r_req_wdata[i] <= m_wdata[i*DATA_W +: DATA_W];
                    r_req_wstrb[i] <= m_wstrb[i*STRB_W +: STRB_W];
                end
            end
        end
    end

    assign s_valid   = r_s_valid;
    assign s_address = r_s_address;
    assign s_wdata   = r_s_wdata;
    assign s_wstrb   = r_s_wstrb;
    assign m_rdata   = r_m_rdata;
    assign m_ready   = r_m_ready;
    assign m_err     = r_m_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_clint_arbiter.sv
// Self-checking bench for clint_arbiter: vector table plus hand sequences,
// with issue/response scoreboard queues checked at every falling edge.
module tb_clint_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_address;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    m_err;
    logic            s_valid;
    logic [AW-1:0]   s_address;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [DW-1:0]   s_rdata;
    logic            s_ready;
    logic            busy;

    always #5 clk = ~clk;

    clint_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_valid(s_valid), .s_address(s_address), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } iss_t;

    typedef struct {
        int            master;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    typedef struct {
        int            master;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            delay;
        logic [DW-1:0] slv_data;
        logic [DW-1:0] exp_rdata;
        int            exp_sv_lat;
        int            exp_rdy_lat;
    } vec_t;

    iss_t iq[$];
    rsp_t rq[$];

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            n_sv = 0;
    int            n_rdy = 0;
    int            sv_cyc = -1;
    int            rdy_cyc = -1;
    int            slave_delay = 2;
    logic [DW-1:0] slave_data = '0;
    bit            slave_en = 1'b1;
    int            late_req_n = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        iss_t         e;
        rsp_t         r;
        logic [N-1:0] mask;
        if (s_valid) begin
            n_sv++;
            sv_cyc = cyc;
            chk("busy_in_issue", 64'(busy), 64'(1));
            if (iq.size() == 0) begin
                chk("unexpected_s_valid", 64'(s_valid), 64'(0));
            end else begin
                e = iq.pop_front();
                chk("s_address", 64'(s_address), 64'(e.addr));
                chk("s_wdata", 64'(s_wdata), 64'(e.wdata));
                chk("s_wstrb", 64'(s_wstrb), 64'(e.wstrb));
            end
        end
        if (m_ready != '0) begin
            n_rdy++;
            rdy_cyc = cyc;
            chk("busy_at_ready", 64'(busy), 64'(0));
            if (rq.size() == 0) begin
                chk("unexpected_m_ready", 64'(m_ready), 64'(0));
            end else begin
                r    = rq.pop_front();
                mask = N'(1) << r.master;
                chk("m_ready", 64'(m_ready), 64'(mask));
                chk("m_err", 64'(m_err), r.err ? 64'(mask) : 64'(0));
                chk("m_rdata", 64'(m_rdata), 64'(r.rdata));
            end
        end else if (m_err != '0) begin
            chk("m_err_alone", 64'(m_err), 64'(0));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
        m_valid                = m_valid | (N'(1) << m);
        m_address[m*AW +: AW]  = a;
        m_wdata[m*DW +: DW]    = d;
        m_wstrb[m*SW +: SW]    = s;
    endtask

    task automatic wait_ready(input int bound, input string name);
        int n0;
        int k;
        n0 = n_rdy;
        k  = 0;
        while (n_rdy == n0 && k < bound) begin
            tick();
            k++;
        end
        chk({name, "_done"}, 64'(n_rdy - n0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_valid"}, 64'(s_valid), 64'(0));
        chk({tag, "_s_address"}, 64'(s_address), 64'(0));
        chk({tag, "_s_wdata"}, 64'(s_wdata), 64'(0));
        chk({tag, "_s_wstrb"}, 64'(s_wstrb), 64'(0));
        chk({tag, "_m_ready"}, 64'(m_ready), 64'(0));
        chk({tag, "_m_err"}, 64'(m_err), 64'(0));
        chk({tag, "_m_rdata"}, 64'(m_rdata), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    // Slave model: answers each s_valid after slave_delay cycles, plus on-demand stray readies.
    initial begin
        int done;
        done    = 0;
        s_ready = 1'b0;
        s_rdata = '0;
        forever begin
            @(negedge clk);
            if (late_req_n != done) begin
                done++;
                @(posedge clk);
                #1;
                s_ready = 1'b1;
                s_rdata = 32'hDEAD_BEEF;
                @(posedge clk);
                #1;
                s_ready = 1'b0;
                s_rdata = '0;
            end else if (s_valid && slave_en) begin
                repeat (slave_delay) @(posedge clk);
                #1;
                s_ready = 1'b1;
                s_rdata = slave_data;
                @(posedge clk);
                #1;
                s_ready = 1'b0;
                s_rdata = '0;
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int   t;
        int   s0;
        int   n0;
        int   k;
        int   issued;

        vecs[0] = '{0, 16'd16384, 32'd20,         4'hF, 2, 32'h0000_0000, 32'h0000_0000, 1, 4};
        vecs[1] = '{1, 16'd49144, 32'h0000_0000,  4'h0, 2, 32'h0000_1234, 32'h0000_1234, 1, 4};
        vecs[2] = '{0, 16'h0004,  32'hCAFE_F00D,  4'h3, 1, 32'h0000_0055, 32'h0000_0055, 1, 3};
        vecs[3] = '{1, 16'hBFF8,  32'h1234_5678,  4'h8, 5, 32'h89AB_CDEF, 32'h89AB_CDEF, 1, 7};

        reset     = 1'b1;
        m_valid   = '0;
        m_address = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        #2 reset  = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Single accesses from the vector table, with latency checks.
        foreach (vecs[v]) begin
            slave_en    = 1'b1;
            slave_delay = vecs[v].delay;
            slave_data  = vecs[v].slv_data;
            drive_req(vecs[v].master, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            iq.push_back('{vecs[v].addr, vecs[v].wdata, vecs[v].wstrb});
            rq.push_back('{vecs[v].master, 1'b0, vecs[v].exp_rdata});
            s0 = n_sv;
            tick();
            t = cyc;
            m_valid = '0;
            wait_ready(50, "vec");
            chk("sv_latency", 64'(sv_cyc - t), 64'(vecs[v].exp_sv_lat));
            chk("rdy_latency", 64'(rdy_cyc - t), 64'(vecs[v].exp_rdy_lat));
            chk("sv_count", 64'(n_sv - s0), 64'(1));
            repeat (2) tick();
        end

        // Contention then fairness: both request together and re-request on every m_ready.
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        slave_delay = 2;
        slave_data  = 32'hA5A5_0001;
        for (int g = 0; g < 6; g++) begin
            iq.push_back('{16'h4000 + AW'((g % 2) * 8), 32'h1111_0000 + DW'(g % 2), 4'hF});
            rq.push_back('{g % 2, 1'b0, 32'hA5A5_0001});
        end
        drive_req(0, 16'h4000, 32'h1111_0000, 4'hF);
        drive_req(1, 16'h4008, 32'h1111_0001, 4'hF);
        issued = 2;
        n0     = n_rdy;
        k      = 0;
        while (n_rdy < n0 + 6 && k < 400) begin
            tick();
            k++;
            m_valid = '0;
            if (m_ready != '0 && issued < 6) begin
                m_valid = m_ready;
                issued++;
            end
        end
        chk("fair_completions", 64'(n_rdy - n0), 64'(6));
        chk("fair_issue_drained", 64'(iq.size()), 64'(0));
        repeat (2) tick();

        // Timeout: slave silent, then a stray s_ready in IDLE.
        slave_en = 1'b0;
        drive_req(1, 16'h0BB8, 32'h7777_7777, 4'hF);
        iq.push_back('{16'h0BB8, 32'h7777_7777, 4'hF});
        rq.push_back('{1, 1'b1, 32'h0});
        tick();
        m_valid = '0;
        wait_ready(400, "timeout");
        chk("timeout_wait_cycles", 64'(rdy_cyc - sv_cyc), 64'(TO + 1));
        n0 = n_rdy;
        late_req_n++;
        repeat (6) tick();
        chk("late_ready_ignored", 64'(n_rdy - n0), 64'(0));
        chk("late_ready_busy", 64'(busy), 64'(0));

        // Reset in the middle of WAIT.
        drive_req(0, 16'h1000, 32'h5555_AAAA, 4'h5);
        iq.push_back('{16'h1000, 32'h5555_AAAA, 4'h5});
        tick();
        m_valid = '0;
        repeat (5) tick();
        chk("busy_before_reset", 64'(busy), 64'(1));
        reset = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (2) tick();
        reset = 1'b1;
        n0 = n_rdy;
        s0 = n_sv;
        repeat (10) tick();
        chk("midrst_no_ready", 64'(n_rdy - n0), 64'(0));
        chk("midrst_no_reissue", 64'(n_sv - s0), 64'(0));
        chk("midrst_issue_drained", 64'(iq.size()), 64'(0));

        // Duplicate m_valid while pending and while in flight.
        slave_en    = 1'b1;
        slave_delay = 4;
        slave_data  = 32'h0D0D_0D0D;
        s0 = n_sv;
        n0 = n_rdy;
        drive_req(0, 16'h2000, 32'hAAAA_0000, 4'hF);
        iq.push_back('{16'h2000, 32'hAAAA_0000, 4'hF});
        rq.push_back('{0, 1'b0, 32'h0D0D_0D0D});
        tick();
        m_valid = '0;
        drive_req(0, 16'h2004, 32'hBBBB_0000, 4'h1);
        tick();
        m_valid = '0;
        drive_req(0, 16'h2008, 32'hCCCC_0000, 4'h2);
        tick();
        m_valid = '0;
        repeat (15) tick();
        chk("dup_sv_count", 64'(n_sv - s0), 64'(1));
        chk("dup_rdy_count", 64'(n_rdy - n0), 64'(1));
        chk("dup_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
